// File: rtl/mem_noc_arb_2to1_pkg.sv
// mem_noc_arb_2to1_pkg: memory NoC payload types, arbiter states and watchdog defaults
package mem_noc_arb_2to1_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        resp_err;
        logic        resp_last;
    } mem_resp_t;
    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] RESP = 1'b1;
    localparam int TIMEOUT_W_DEF   = 8;
    localparam int TIMEOUT_CYC_DEF = 200;
endpackage

// File: rtl/mem_noc_rr_arb2.sv
// mem_noc_rr_arb2: 2-way round-robin grant; pointer moves past the winner when upd is high
module mem_noc_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic       grant,
    output logic       ptr
);
    always_comb grant = req[ptr] ? ptr : (req[~ptr] ? ~ptr : ptr);
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= 1'b0;
        else if (upd) ptr <= ~grant;
endmodule

// File: rtl/mem_noc_arb_2to1.sv
// mem_noc_arb_2to1: two masters share one slave, one outstanding transaction, round-robin with watchdog
module mem_noc_arb_2to1
    import mem_noc_arb_2to1_pkg::*;
#(
    parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      mn0_req_valid,
    output logic      mn0_req_ready,
    input  mem_req_t  mn0_req,
    output logic      mn0_resp_valid,
    input  logic      mn0_resp_ready,
    output mem_resp_t mn0_resp,
    input  logic      mn1_req_valid,
    output logic      mn1_req_ready,
    input  mem_req_t  mn1_req,
    output logic      mn1_resp_valid,
    input  logic      mn1_resp_ready,
    output mem_resp_t mn1_resp,
    output logic      sn_req_valid,
    input  logic      sn_req_ready,
    output mem_req_t  sn_req,
    input  logic      sn_resp_valid,
    output logic      sn_resp_ready,
    input  mem_resp_t sn_resp,
    output logic      arb_owner,
    output logic      arb_busy,
    output logic      arb_timeout
);
    logic                 state, owner, timeout_q, grant, rr_ptr;
    logic                 win, req_hs, resp_hs, last_hs, wd_hit;
    logic [TIMEOUT_W-1:0] wdog;
    logic [1:0]           req_v;

    assign req_v = {mn1_req_valid, mn0_req_valid};

    mem_noc_rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (req_v),
        .upd   (req_hs),
        .grant (grant),
        .ptr   (rr_ptr)
    );

    // The issue window reopens on the owner's last beat so the next request issues without a bubble
    always_comb begin
        sn_resp_ready  = (state == RESP) ? (owner ? mn1_resp_ready : mn0_resp_ready) : 1'b1;
        resp_hs        = sn_resp_valid & sn_resp_ready;
        last_hs        = resp_hs & sn_resp.resp_last;
        win            = (state == ARB) | last_hs;
        sn_req_valid   = win & req_v[grant];
        sn_req         = grant ? mn1_req : mn0_req;
        mn0_req_ready  = win & ~grant & sn_req_ready;
        mn1_req_ready  = win & grant & sn_req_ready;
        req_hs         = sn_req_valid & sn_req_ready;
        mn0_resp_valid = (state == RESP) & ~owner & sn_resp_valid;
        mn1_resp_valid = (state == RESP) & owner & sn_resp_valid;
        mn0_resp       = sn_resp;
        mn1_resp       = sn_resp;
        wd_hit         = (TIMEOUT_CYC > 0) && (wdog == TIMEOUT_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= ARB;
            owner     <= 1'b0;
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (req_hs) begin
                state <= RESP;
                owner <= grant;
                wdog  <= '0;
            end else if (state == RESP) begin
                if (last_hs) state <= ARB;
                else if (resp_hs) wdog <= '0;
                else if (wd_hit) begin
                    state     <= ARB;
                    timeout_q <= 1'b1;
                end else if (wdog != '1) wdog <= wdog + TIMEOUT_W'(1);
            end
        end

    assign arb_owner   = owner;
    assign arb_busy    = (state == RESP);
    assign arb_timeout = timeout_q;
endmodule

// File: tb/tb_mem_noc_arb_2to1.sv
// tb_mem_noc_arb_2to1: directed scenarios with queue scoreboard checked by a negedge monitor
module tb_mem_noc_arb_2to1;
    import mem_noc_arb_2to1_pkg::*;

    logic      clk, rst;
    logic      mn0_req_valid, mn0_req_ready, mn0_resp_valid, mn0_resp_ready;
    logic      mn1_req_valid, mn1_req_ready, mn1_resp_valid, mn1_resp_ready;
    mem_req_t  mn0_req, mn1_req, sn_req;
    mem_resp_t mn0_resp, mn1_resp, sn_resp;
    logic      sn_req_valid, sn_req_ready, sn_resp_valid, sn_resp_ready;
    logic      arb_owner, arb_busy, arb_timeout;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_req[$];
    logic [31:0] exp_r0[$];
    logic [31:0] exp_r1[$];

    mem_noc_arb_2to1 #(.TIMEOUT_W(8), .TIMEOUT_CYC(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .mn0_req_valid  (mn0_req_valid),
        .mn0_req_ready  (mn0_req_ready),
        .mn0_req        (mn0_req),
        .mn0_resp_valid (mn0_resp_valid),
        .mn0_resp_ready (mn0_resp_ready),
        .mn0_resp       (mn0_resp),
        .mn1_req_valid  (mn1_req_valid),
        .mn1_req_ready  (mn1_req_ready),
        .mn1_req        (mn1_req),
        .mn1_resp_valid (mn1_resp_valid),
        .mn1_resp_ready (mn1_resp_ready),
        .mn1_resp       (mn1_resp),
        .sn_req_valid   (sn_req_valid),
        .sn_req_ready   (sn_req_ready),
        .sn_req         (sn_req),
        .sn_resp_valid  (sn_resp_valid),
        .sn_resp_ready  (sn_resp_ready),
        .sn_resp        (sn_resp),
        .arb_owner      (arb_owner),
        .arb_busy       (arb_busy),
        .arb_timeout    (arb_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every handshake the DUT presents must match the next queued expectation
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (sn_req_valid && sn_req_ready) begin
                if (exp_req.size() == 0) chk("req_unexpected", sn_req_valid, 0);
                else chk("req_addr", sn_req.addr, exp_req.pop_front());
            end
            if (mn0_resp_valid) begin
                if (exp_r0.size() == 0) chk("r0_unexpected", mn0_resp_valid, 0);
                else if (mn0_resp_ready) chk("r0_data", mn0_resp.rdata, exp_r0.pop_front());
            end
            if (mn1_resp_valid) begin
                if (exp_r1.size() == 0) chk("r1_unexpected", mn1_resp_valid, 0);
                else if (mn1_resp_ready) chk("r1_data", mn1_resp.rdata, exp_r1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_dut;
        rst = 1'b1;
        mn0_req_valid = 0; mn1_req_valid = 0;
        mn0_req = '0; mn1_req = '0;
        mn0_resp_ready = 1; mn1_resp_ready = 1;
        sn_req_ready = 1; sn_resp_valid = 0; sn_resp = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", arb_busy, 0);
        chk("rst_timeout", arb_timeout, 0);
        chk("rst_sn_resp_ready", sn_resp_ready, 1);
        chk("rst_owner", arb_owner, 0);
        tick();
    endtask

    task automatic burst(input int m, input int nb, input logic [31:0] base, input int nxt);
        for (int j = 0; j < nb; j++) begin
            sn_resp_valid = 1;
            sn_resp.rdata = base + j;
            sn_resp.resp_last = (j == nb - 1);
            sn_resp.resp_err = 0;
            if (m == 0) exp_r0.push_back(base + j);
            else exp_r1.push_back(base + j);
            @(negedge clk);
            if (nxt == 0) chk("next_rdy0", mn0_req_ready, j == nb - 1);
            else if (nxt == 1) chk("next_rdy1", mn1_req_ready, j == nb - 1);
            tick();
        end
        sn_resp_valid = 0;
        sn_resp.resp_last = 0;
    endtask

    initial begin
        rst = 1'b1;
        rst_dut();
        // single master, single beat
        mn0_req_valid = 1; mn0_req.addr = 'h100;
        exp_req.push_back('h100);
        @(negedge clk);
        chk("t1_sn_valid", sn_req_valid, 1);
        chk("t1_mn1_rdy", mn1_req_ready, 0);
        tick();
        mn0_req_valid = 0;
        @(negedge clk);
        chk("t1_busy", arb_busy, 1);
        chk("t1_owner", arb_owner, 0);
        tick();
        burst(0, 1, 'hA0, -1);
        @(negedge clk);
        chk("t1_idle", arb_busy, 0);
        tick();
        // both masters contending, 4-beat bursts, zero-bubble alternation
        rst_dut();
        mn0_req_valid = 1; mn0_req.addr = 'h200;
        mn1_req_valid = 1; mn1_req.addr = 'h300;
        exp_req.push_back('h200); exp_req.push_back('h300);
        exp_req.push_back('h201); exp_req.push_back('h301);
        @(negedge clk);
        chk("t2_rdy0", mn0_req_ready, 1);
        chk("t2_rdy1", mn1_req_ready, 0);
        tick();
        mn0_req.addr = 'h201;
        burst(0, 4, 'h2000, 1);
        mn1_req.addr = 'h301;
        burst(1, 4, 'h3000, 0);
        mn0_req_valid = 0;
        burst(0, 4, 'h2100, 1);
        mn1_req_valid = 0;
        burst(1, 4, 'h3100, -1);
        // mn1 waits behind an 8-beat burst
        rst_dut();
        mn0_req_valid = 1; mn0_req.addr = 'h400;
        mn1_req_valid = 1; mn1_req.addr = 'h500;
        exp_req.push_back('h400); exp_req.push_back('h500);
        tick();
        mn0_req_valid = 0;
        burst(0, 8, 'h4000, 1);
        mn1_req_valid = 0;
        burst(1, 1, 'h5000, -1);
        // slave stalls request; late mn1 must not steal the grant
        rst_dut();
        sn_req_ready = 0;
        mn0_req_valid = 1; mn0_req.addr = 'h600;
        exp_req.push_back('h600); exp_req.push_back('h700);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin mn1_req_valid = 1; mn1_req.addr = 'h700; end
            @(negedge clk);
            chk("t4_hold_addr", sn_req.addr, 'h600);
            chk("t4_hold_valid", sn_req_valid, 1);
            tick();
        end
        sn_req_ready = 1;
        @(negedge clk);
        chk("t4_rdy0", mn0_req_ready, 1);
        tick();
        mn0_req_valid = 0;
        @(negedge clk);
        chk("t4_owner", arb_owner, 0);
        tick();
        burst(0, 1, 'h6000, 1);
        mn1_req_valid = 0;
        burst(1, 1, 'h7000, -1);
        // silent slave, watchdog abort, late beat drained
        rst_dut();
        mn0_req_valid = 1; mn0_req.addr = 'h800;
        exp_req.push_back('h800);
        tick();
        mn0_req_valid = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            chk("t5_timeout", arb_timeout, c == 17);
            if (c == 17) chk("t5_busy", arb_busy, 0);
            tick();
        end
        sn_resp_valid = 1; sn_resp.rdata = 'hDEAD; sn_resp.resp_last = 1;
        @(negedge clk);
        chk("t5_drain_rdy", sn_resp_ready, 1);
        chk("t5_r0_valid", mn0_resp_valid, 0);
        chk("t5_r1_valid", mn1_resp_valid, 0);
        chk("t5_pulse_end", arb_timeout, 0);
        tick();
        sn_resp_valid = 0; sn_resp.resp_last = 0;
        // asynchronous reset in the middle of a burst
        rst_dut();
        mn0_req_valid = 1; mn0_req.addr = 'h900;
        exp_req.push_back('h900);
        tick();
        mn0_req_valid = 0;
        sn_resp_valid = 1; sn_resp.rdata = 'h9000; sn_resp.resp_last = 0;
        exp_r0.push_back('h9000);
        @(negedge clk);
        tick();
        sn_resp.rdata = 'h9001;
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", arb_busy, 0);
        chk("t6_r0_valid", mn0_resp_valid, 0);
        chk("t6_sn_resp_ready", sn_resp_ready, 1);
        chk("t6_owner", arb_owner, 0);
        sn_resp_valid = 0;
        tick();
        rst = 1'b0;
        mn0_req_valid = 1; mn0_req.addr = 'hA00;
        mn1_req_valid = 1; mn1_req.addr = 'hB00;
        exp_req.push_back('hA00);
        @(negedge clk);
        chk("t6_pref0", mn0_req_ready, 1);
        chk("t6_pref1", mn1_req_ready, 0);
        tick();
        mn0_req_valid = 0; mn1_req_valid = 0;
        burst(0, 1, 'hA000, -1);
        tick();
        chk("q_req_empty", exp_req.size(), 0);
        chk("q_r0_empty", exp_r0.size(), 0);
        chk("q_r1_empty", exp_r1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
